// File: rtl/clock_disp_pkg.sv
// Shared definitions for the clock display formatter.
//   - digit codes understood by the scan driver
//   - display mode, edit field and FSM state enums
//   - snapshot struct holding one set of broken-down UTC fields
//   - range limits and small digit-forming helpers
package clock_disp_pkg;

    localparam logic [3:0] DIG_DASH  = 4'd10;
    localparam logic [3:0] DIG_BLANK = 4'd15;

    // Binary input width and BCD output width of the shared converter.
    localparam int BIN_W = 14;
    localparam int BCD_W = 20;

    localparam logic [3:0] MONTH_MAX  = 4'd12;
    localparam logic [4:0] DAY_MAX    = 5'd31;
    localparam logic [4:0] HOUR_MAX   = 5'd23;
    localparam logic [5:0] MINUTE_MAX = 6'd59;
    localparam logic [5:0] SECOND_MAX = 6'd59;
    localparam logic [2:0] WDAY_MAX   = 3'd6;

    // Decimal-point masks (active low), bit i belongs to digit i.
    localparam logic [7:0] DP_DATE = 8'b1110_1011;
    localparam logic [7:0] DP_WDAY = 8'b1111_1011;
    localparam logic [7:0] DP_NONE = 8'b1111_1111;

    typedef enum logic [1:0] {
        MODE_DATE  = 2'd0,
        MODE_TIME  = 2'd1,
        MODE_WDAY  = 2'd2,
        MODE_BLANK = 2'd3
    } mode_e;

    // Also used as the conversion sequence index (year..second).
    typedef enum logic [2:0] {
        EF_NONE   = 3'd0,
        EF_YEAR   = 3'd1,
        EF_MONTH  = 3'd2,
        EF_DAY    = 3'd3,
        EF_HOUR   = 3'd4,
        EF_MINUTE = 3'd5,
        EF_SECOND = 3'd6
    } field_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_PACK  = 2'd3
    } state_e;

    typedef struct packed {
        logic [BIN_W-1:0] year;
        logic [3:0]       month;
        logic [4:0]       day;
        logic [2:0]       weekday;
        logic [4:0]       hour;
        logic [5:0]       minute;
        logic [5:0]       second;
    } fields_t;

    function automatic field_e next_field(input field_e f);
        case (f)
            EF_YEAR:   next_field = EF_MONTH;
            EF_MONTH:  next_field = EF_DAY;
            EF_DAY:    next_field = EF_HOUR;
            EF_HOUR:   next_field = EF_MINUTE;
            default:   next_field = EF_SECOND;
        endcase
    endfunction

    // Two display digits for a field: blank wins over dash, dash over value.
    function automatic logic [7:0] two_digits(input logic [7:0] bcd,
                                              input logic       ok,
                                              input logic       blank);
        two_digits = bcd;
        if (!ok)
            two_digits = {DIG_DASH, DIG_DASH};
        if (blank)
            two_digits = {DIG_BLANK, DIG_BLANK};
    endfunction

    function automatic logic [15:0] four_digits(input logic [15:0] bcd,
                                                input logic        ok,
                                                input logic        blank);
        four_digits = bcd;
        if (!ok)
            four_digits = {4{DIG_DASH}};
        if (blank)
            four_digits = {4{DIG_BLANK}};
    endfunction

endpackage

// File: rtl/serial_bin2bcd.sv
// Iterative double-dabble binary-to-BCD converter.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load bin/width and begin converting
//   bin        : binary value, only the low `width` bits are significant
//   width      : number of significant bits (1..14), one cycle per bit
//   done       : one-cycle pulse the cycle after the last shift
//   bcd        : 5-digit BCD result, stable from done until the next start
module serial_bin2bcd
    import clock_disp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    input  logic [3:0]       width,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [BCD_W-1:0] adj;
    logic [3:0]       shamt;

    always_comb begin
        // Add 3 to each nibble >= 5 so it carries correctly after the shift.
        adj = bcd_q;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        bcd_d  = bcd_q;
        bin_d  = bin_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        shamt  = 4'(BIN_W) - width;
        if (start) begin
            // Left-align the significant bits so the MSB shifts out first.
            bcd_d = '0;
            bin_d = bin << shamt;
            cnt_d = width;
        end else if (cnt_q != 4'd0) begin
            {bcd_d, bin_d} = {adj, bin_q} << 1;
            cnt_d  = cnt_q - 4'd1;
            done_d = (cnt_q == 4'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q  <= '0;
            bin_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            bin_q  <= bin_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/clock_display_formatter.sv
// Clock display formatter: snapshots UTC fields, converts each one to BCD on
// a shared serial double-dabble engine, range-checks them and packs a
// mode-selected digit / decimal-point word with edit-field blinking.
//   fields_valid + year..second : field snapshot strobe and field values
//   mode, edit_field, blink_tick: layout select, edited field, blink toggle
//   busy                        : conversion in progress (or pending)
//   seg_valid                   : one-cycle pulse when eight_segment updates
//   eight_segment               : {digit codes (digit N-1 at MSBs), dp mask}
module clock_display_formatter
    import clock_disp_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int YEAR_W   = 14
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fields_valid,
    input  logic [YEAR_W-1:0]     year,
    input  logic [3:0]            month,
    input  logic [4:0]            day,
    input  logic [2:0]            weekday,
    input  logic [4:0]            hour,
    input  logic [5:0]            minute,
    input  logic [5:0]            second,
    input  logic [1:0]            mode,
    input  logic [2:0]            edit_field,
    input  logic                  blink_tick,
    output logic                  busy,
    output logic                  seg_valid,
    output logic [5*N_DIGITS-1:0] eight_segment
);

    localparam int SEG_W = 5 * N_DIGITS;

    state_e            state_q, state_d;
    field_e            fld_q, fld_d;          // field the FSM is working on
    field_e            res_fld_q, res_fld_d;  // field currently inside the engine
    logic [3:0]        cnt_q, cnt_d;
    fields_t           snap_q, snap_d;
    fields_t           pend_q, pend_d;
    logic              pend_flag_q, pend_flag_d;
    logic              busy_q, busy_d;
    logic              blink_phase_q, blink_phase_d;
    mode_e             mode_q, mode_d;
    field_e            edit_q, edit_d;
    logic [BCD_W-1:0]  held_year_q, held_year_d;
    logic [7:0]        held_month_q, held_month_d;
    logic [7:0]        held_day_q, held_day_d;
    logic [7:0]        held_hour_q, held_hour_d;
    logic [7:0]        held_minute_q, held_minute_d;
    logic [7:0]        held_second_q, held_second_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic              seg_valid_q, seg_valid_d;

    fields_t           in_f;
    logic              repack;
    logic              eng_start;
    logic              eng_done;
    logic [BIN_W-1:0]  eng_bin;
    logic [3:0]        eng_width;
    logic [BCD_W-1:0]  eng_bcd;
    logic [SEG_W-1:0]  pack_word;

    always_comb begin
        in_f         = '0;
        in_f.year    = BIN_W'(year);
        in_f.month   = month;
        in_f.day     = day;
        in_f.weekday = weekday;
        in_f.hour    = hour;
        in_f.minute  = minute;
        in_f.second  = second;
    end

    // ------------------------------------------------------------------
    // Shared converter
    // ------------------------------------------------------------------
    always_comb begin
        eng_bin   = '0;
        eng_width = 4'd0;
        case (fld_q)
            EF_YEAR:   begin eng_bin = snap_q.year;          eng_width = 4'(YEAR_W); end
            EF_MONTH:  begin eng_bin = BIN_W'(snap_q.month);  eng_width = 4'd4; end
            EF_DAY:    begin eng_bin = BIN_W'(snap_q.day);    eng_width = 4'd5; end
            EF_HOUR:   begin eng_bin = BIN_W'(snap_q.hour);   eng_width = 4'd5; end
            EF_MINUTE: begin eng_bin = BIN_W'(snap_q.minute); eng_width = 4'd6; end
            EF_SECOND: begin eng_bin = BIN_W'(snap_q.second); eng_width = 4'd6; end
            default:   ;
        endcase
    end

    serial_bin2bcd u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (eng_start),
        .bin   (eng_bin),
        .width (eng_width),
        .done  (eng_done),
        .bcd   (eng_bcd)
    );

    // The engine finishes one cycle after the last SHIFT, i.e. during the
    // next field's LOAD or during PACK; res_fld_q still names the finished
    // field then. PACK reads the _d values so the last field is included.
    always_comb begin
        held_year_d   = held_year_q;
        held_month_d  = held_month_q;
        held_day_d    = held_day_q;
        held_hour_d   = held_hour_q;
        held_minute_d = held_minute_q;
        held_second_d = held_second_q;
        if (eng_done) begin
            case (res_fld_q)
                EF_YEAR:   held_year_d   = eng_bcd;
                EF_MONTH:  held_month_d  = eng_bcd[7:0];
                EF_DAY:    held_day_d    = eng_bcd[7:0];
                EF_HOUR:   held_hour_d   = eng_bcd[7:0];
                EF_MINUTE: held_minute_d = eng_bcd[7:0];
                EF_SECOND: held_second_d = eng_bcd[7:0];
                default:   ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Packing
    // ------------------------------------------------------------------
    logic [15:0]      yr_dig;
    logic [7:0]       mo_dig, dy_dig, hr_dig, mi_dig, se_dig;
    logic [3:0]       wd_dig;
    logic [31:0]      dig_word;
    logic [7:0]       dp_word;
    logic [4*N_DIGITS-1:0] all_dig;
    logic [N_DIGITS-1:0]   all_dp;

    always_comb begin
        // The year is in range exactly when its fifth BCD digit is zero.
        yr_dig = four_digits(held_year_d[15:0], held_year_d[19:16] == 4'd0,
                             blink_phase_q && (edit_q == EF_YEAR));
        mo_dig = two_digits(held_month_d,
                            (snap_q.month != 4'd0) && (snap_q.month <= MONTH_MAX),
                            blink_phase_q && (edit_q == EF_MONTH));
        dy_dig = two_digits(held_day_d,
                            (snap_q.day != 5'd0) && (snap_q.day <= DAY_MAX),
                            blink_phase_q && (edit_q == EF_DAY));
        hr_dig = two_digits(held_hour_d, snap_q.hour <= HOUR_MAX,
                            blink_phase_q && (edit_q == EF_HOUR));
        mi_dig = two_digits(held_minute_d, snap_q.minute <= MINUTE_MAX,
                            blink_phase_q && (edit_q == EF_MINUTE));
        se_dig = two_digits(held_second_d, snap_q.second <= SECOND_MAX,
                            blink_phase_q && (edit_q == EF_SECOND));
        wd_dig = (snap_q.weekday <= WDAY_MAX) ? {1'b0, snap_q.weekday} : DIG_DASH;

        case (mode_q)
            MODE_DATE: begin
                dig_word = {yr_dig, mo_dig, dy_dig};
                dp_word  = DP_DATE;
            end
            MODE_TIME: begin
                dig_word = {hr_dig, DIG_DASH, mi_dig, DIG_DASH, se_dig};
                dp_word  = DP_NONE;
            end
            MODE_WDAY: begin
                dig_word = {DIG_BLANK, wd_dig, DIG_DASH, DIG_BLANK, hr_dig, mi_dig};
                dp_word  = DP_WDAY;
            end
            default: begin
                dig_word = {8{DIG_BLANK}};
                dp_word  = DP_NONE;
            end
        endcase

        // Digits above 7 stay blank (code 15 is all ones) with no dot.
        all_dig       = '1;
        all_dig[31:0] = dig_word;
        all_dp        = '1;
        all_dp[7:0]   = dp_word;
        pack_word     = {all_dig, all_dp};
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        blink_phase_d = blink_phase_q ^ blink_tick;
        mode_d        = mode_e'(mode);
        edit_d        = field_e'(edit_field);
        repack        = (mode_e'(mode) != mode_q) ||
                        (field_e'(edit_field) != edit_q) || blink_tick;
    end

    always_comb begin
        state_d     = state_q;
        fld_d       = fld_q;
        res_fld_d   = res_fld_q;
        cnt_d       = cnt_q;
        snap_d      = snap_q;
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        busy_d      = busy_q;
        seg_d       = seg_q;
        seg_valid_d = 1'b0;
        eng_start   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fields_valid) begin
                    snap_d  = in_f;
                    busy_d  = 1'b1;
                    fld_d   = EF_YEAR;
                    state_d = ST_LOAD;
                end else if (repack) begin
                    state_d = ST_PACK;
                end
            end
            ST_LOAD: begin
                eng_start = 1'b1;
                res_fld_d = fld_q;
                cnt_d     = eng_width;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (fld_q == EF_SECOND) begin
                        state_d = ST_PACK;
                    end else begin
                        fld_d   = next_field(fld_q);
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_PACK: begin
                seg_d       = pack_word;
                seg_valid_d = 1'b1;
                if (fields_valid) begin
                    // A strobe landing on PACK is newer than anything pending.
                    snap_d      = in_f;
                    pend_flag_d = 1'b0;
                    busy_d      = 1'b1;
                    fld_d       = EF_YEAR;
                    state_d     = ST_LOAD;
                end else if (pend_flag_q) begin
                    snap_d      = pend_q;
                    pend_flag_d = 1'b0;
                    busy_d      = 1'b1;
                    fld_d       = EF_YEAR;
                    state_d     = ST_LOAD;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (((state_q == ST_LOAD) || (state_q == ST_SHIFT)) && fields_valid) begin
            pend_d      = in_f;
            pend_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            fld_q         <= EF_NONE;
            res_fld_q     <= EF_NONE;
            cnt_q         <= '0;
            snap_q        <= '0;
            pend_q        <= '0;
            pend_flag_q   <= 1'b0;
            busy_q        <= 1'b0;
            blink_phase_q <= 1'b0;
            mode_q        <= MODE_DATE;
            edit_q        <= EF_NONE;
            held_year_q   <= '0;
            held_month_q  <= '0;
            held_day_q    <= '0;
            held_hour_q   <= '0;
            held_minute_q <= '0;
            held_second_q <= '0;
            seg_q         <= '0;
            seg_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            fld_q         <= fld_d;
            res_fld_q     <= res_fld_d;
            cnt_q         <= cnt_d;
            snap_q        <= snap_d;
            pend_q        <= pend_d;
            pend_flag_q   <= pend_flag_d;
            busy_q        <= busy_d;
            blink_phase_q <= blink_phase_d;
            mode_q        <= mode_d;
            edit_q        <= edit_d;
            held_year_q   <= held_year_d;
            held_month_q  <= held_month_d;
            held_day_q    <= held_day_d;
            held_hour_q   <= held_hour_d;
            held_minute_q <= held_minute_d;
            held_second_q <= held_second_d;
            seg_q         <= seg_d;
            seg_valid_q   <= seg_valid_d;
        end
    end

    assign busy          = busy_q;
    assign seg_valid     = seg_valid_q;
    assign eight_segment = seg_q;

endmodule

// File: tb/tb_clock_display_formatter.sv
module tb_clock_display_formatter;

    localparam int N  = 8;
    localparam int YW = 14;
    localparam int SW = 5 * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fields_valid = 1'b0;
    logic [YW-1:0] year = '0;
    logic [3:0]    month = '0;
    logic [4:0]    day = '0;
    logic [2:0]    weekday = '0;
    logic [4:0]    hour = '0;
    logic [5:0]    minute = '0;
    logic [5:0]    second = '0;
    logic [1:0]    mode = '0;
    logic [2:0]    edit_field = '0;
    logic          blink_tick = 1'b0;
    logic          busy;
    logic          seg_valid;
    logic [SW-1:0] eight_segment;

    int checks = 0;
    int errors = 0;
    logic [SW-1:0] exp_q[$];

    // Bench-side view of what the display should be built from.
    int h_yr, h_mo, h_dy, h_wd, h_hr, h_mi, h_se;
    int m_mode, m_edit;
    bit m_phase;

    clock_display_formatter #(.N_DIGITS(N), .YEAR_W(YW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fields_valid  (fields_valid),
        .year          (year),
        .month         (month),
        .day           (day),
        .weekday       (weekday),
        .hour          (hour),
        .minute        (minute),
        .second        (second),
        .mode          (mode),
        .edit_field    (edit_field),
        .blink_tick    (blink_tick),
        .busy          (busy),
        .seg_valid     (seg_valid),
        .eight_segment (eight_segment)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] pair(input int v, input bit ok, input bit blk);
        if (blk) return 8'hFF;
        if (!ok) return 8'hAA;
        return {4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [SW-1:0] model_word();
        logic [15:0] yd;
        logic [7:0]  mo, dy, hr, mi, se;
        logic [3:0]  wd;
        logic [31:0] dg;
        logic [7:0]  dp;
        if (m_phase && m_edit == 1)  yd = 16'hFFFF;
        else if (h_yr > 9999)        yd = 16'hAAAA;
        else yd = {4'(h_yr / 1000 % 10), 4'(h_yr / 100 % 10), 4'(h_yr / 10 % 10), 4'(h_yr % 10)};
        mo = pair(h_mo, h_mo >= 1 && h_mo <= 12, m_phase && m_edit == 2);
        dy = pair(h_dy, h_dy >= 1 && h_dy <= 31, m_phase && m_edit == 3);
        hr = pair(h_hr, h_hr <= 23, m_phase && m_edit == 4);
        mi = pair(h_mi, h_mi <= 59, m_phase && m_edit == 5);
        se = pair(h_se, h_se <= 59, m_phase && m_edit == 6);
        wd = (h_wd <= 6) ? 4'(h_wd) : 4'hA;
        case (m_mode)
            0:       begin dg = {yd, mo, dy};                      dp = 8'b1110_1011; end
            1:       begin dg = {hr, 4'hA, mi, 4'hA, se};          dp = 8'hFF; end
            2:       begin dg = {4'hF, wd, 4'hA, 4'hF, hr, mi};    dp = 8'b1111_1011; end
            default: begin dg = 32'hFFFF_FFFF;                     dp = 8'hFF; end
        endcase
        return {dg, dp};
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && seg_valid) begin
            if (exp_q.size() == 0)
                chk("sb_unexpected_valid", 1, 0);
            else
                chk("sb_word", eight_segment, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input int yr, input int mo, input int dy, input int wd,
                              input int hr, input int mi, input int se);
        year    = YW'(yr);
        month   = 4'(mo);
        day     = 5'(dy);
        weekday = 3'(wd);
        hour    = 5'(hr);
        minute  = 6'(mi);
        second  = 6'(se);
    endtask

    // Strobe fields_valid so it is sampled at the next edge ("edge 0").
    task automatic capture(input int md, input bit push);
        mode         = 2'(md);
        m_mode       = md;
        fields_valid = 1'b1;
        h_yr = int'(year);   h_mo = int'(month); h_dy = int'(day);
        h_wd = int'(weekday); h_hr = int'(hour); h_mi = int'(minute); h_se = int'(second);
        if (push) exp_q.push_back(model_word());
        tick();
        fields_valid = 1'b0;
    endtask

    task automatic full_conv(input int md);
        int n;
        bit allb;
        capture(md, 1'b1);
        chk("conv_busy_start", busy, 1);
        n = 0;
        allb = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (seg_valid) begin
                n = i;
                break;
            end
            if (!busy) allb = 1'b0;
        end
        chk("conv_latency", n, 47);
        chk("conv_busy_hold", allb, 1);
        chk("conv_busy_end", busy, 0);
    endtask

    task automatic repack(input int md, input int ed, input bit blk);
        int n;
        mode       = 2'(md);
        edit_field = 3'(ed);
        blink_tick = blk;
        m_mode     = md;
        m_edit     = ed;
        if (blk) m_phase = !m_phase;
        exp_q.push_back(model_word());
        tick();
        blink_tick = 1'b0;
        chk("repack_no_busy0", busy, 0);
        n = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (seg_valid) begin
                n = i;
                break;
            end
        end
        chk("repack_latency", n, 1);
        chk("repack_no_busy1", busy, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int first_v, second_v, cnt;
        bit allb;

        m_mode = 0; m_edit = 0; m_phase = 1'b0;
        h_yr = 0; h_mo = 0; h_dy = 0; h_wd = 0; h_hr = 0; h_mi = 0; h_se = 0;

        // Reset state
        repeat (3) tick();
        chk("rst_seg", eight_segment, 0);
        chk("rst_seg_valid", seg_valid, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // Date conversion
        set_fields(2024, 8, 30, 5, 16, 14, 50);
        full_conv(0);
        chk("date_word", eight_segment, 40'h2024_0830_EB);

        // Time re-pack from IDLE
        repack(1, 0, 1'b0);
        chk("time_word", eight_segment, 40'h16A1_4A50_FF);

        // Minute blinking
        repack(1, 5, 1'b0);
        repack(1, 5, 1'b1);
        chk("blink_min_off", eight_segment[27:20], 8'hFF);
        repack(1, 5, 1'b1);
        chk("blink_min_on", eight_segment[27:20], 8'h14);

        // Weekday layout, then blank
        repack(2, 0, 1'b0);
        repack(3, 0, 1'b0);

        // Out-of-range hour and month
        set_fields(2024, 13, 30, 5, 24, 14, 50);
        full_conv(1);
        chk("hour_dash", eight_segment[39:32], 8'hAA);
        repack(0, 0, 1'b0);
        chk("month_dash", eight_segment[23:16], 8'hAA);

        // Random captures, including out-of-range values
        for (int k = 0; k < 4; k++) begin
            edit_field = 3'($urandom_range(0, 6));
            m_edit     = int'(edit_field);
            set_fields($urandom_range(0, 16383), $urandom_range(0, 13), $urandom_range(0, 31),
                       $urandom_range(0, 7), $urandom_range(0, 25), $urandom_range(0, 61),
                       $urandom_range(0, 61));
            full_conv($urandom_range(0, 3));
        end

        // Pending capture during a conversion
        repack(1, 0, 1'b0);
        set_fields(2024, 8, 30, 5, 16, 14, 50);
        capture(1, 1'b1);
        first_v = 0;
        second_v = 0;
        allb = 1'b1;
        for (int i = 1; i <= 150; i++) begin
            tick();
            if (i == 19) begin
                set_fields(2024, 8, 30, 5, 16, 14, 51);
                fields_valid = 1'b1;
                h_se = 51;
                exp_q.push_back(model_word());
            end
            if (i == 20) fields_valid = 1'b0;
            if (seg_valid) begin
                if (first_v == 0) first_v = i;
                else second_v = i;
            end
            if (i < 94 && !busy) allb = 1'b0;
            if (second_v != 0) break;
        end
        chk("pend_first_pack", first_v, 47);
        chk("pend_second_pack", second_v, 94);
        chk("pend_busy_hold", allb, 1);
        chk("pend_seconds", eight_segment[15:8], 8'h51);

        // Reset in the middle of a conversion
        repack(0, 0, 1'b0);
        capture(0, 1'b0);
        for (int i = 1; i < 30; i++) tick();
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_seg", eight_segment, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", seg_valid, 0);
        m_phase = 1'b0;
        h_yr = 0; h_mo = 0; h_dy = 0; h_wd = 0; h_hr = 0; h_mi = 0; h_se = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (seg_valid) cnt++;
        end
        chk("midrst_no_pulse", cnt, 0);
        // Held results were cleared: time view shows 00-00-00.
        repack(1, 0, 1'b0);
        chk("midrst_held_zero", eight_segment, 40'h00A0_0A00_FF);

        tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #400000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
